// File: rtl/reg_scoreboard.sv
// reg_scoreboard
//   Issue-side register scoreboard. For each of the 16 architectural
//   registers it counts the issued writers that have not yet written back.
//   Decode is stalled when it reads a register that has a pending writer,
//   or when its destination counter is already at its maximum.
//   Issue records writers. Write-back and squash retire them.
//
// Ports
//   clk, rst       rising-edge clock, asynchronous active-high reset
//   issue_valid    decode holds an instruction requesting issue
//   issue_wb_en    that instruction writes issue_dest
//   issue_dest     destination register of the decoding instruction
//   src1, src2     source registers (src2 only read when two_src)
//   two_src        src2 is a real operand
//   wb_valid/dest  a writer retires by write-back this cycle
//   kill_valid/dest a writer is squashed this cycle
//   stall          combinational issue block
//   issue_fire     instruction accepted this cycle (issue_valid & ~stall)
//   busy[r]        registered: register r has at least one pending writer
//   err            sticky: a retire arrived for a register with no writer
module reg_scoreboard #(
  parameter int CNT_W = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        issue_valid,
  input  logic        issue_wb_en,
  input  logic [3:0]  issue_dest,
  input  logic [3:0]  src1,
  input  logic [3:0]  src2,
  input  logic        two_src,
  input  logic        wb_valid,
  input  logic [3:0]  wb_dest,
  input  logic        kill_valid,
  input  logic [3:0]  kill_dest,
  output logic        stall,
  output logic        issue_fire,
  output logic [15:0] busy,
  output logic        err
);

  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

  logic [CNT_W-1:0] cnt_r      [16];
  logic [CNT_W-1:0] cnt_nxt_s  [16];
  logic [CNT_W:0]   sum_s      [16];
  logic [CNT_W:0]   dec_s      [16];
  logic [15:0]      busy_r;
  logic [15:0]      busy_nxt_s;
  logic [15:0]      under_s;
  logic             err_r;
  logic             stall_s;
  logic             fire_s;
  logic             dest_full_s;

  // Hazard check against registered state only: a retire in this same
  // cycle does not release the dependent until the next cycle.
  always_comb begin
    dest_full_s = (cnt_r[issue_dest] == CNT_MAX);
    if (issue_valid) begin
      stall_s = busy_r[src1] | (two_src & busy_r[src2]) | (issue_wb_en & dest_full_s);
    end else begin
      stall_s = 1'b0;
    end
    fire_s = issue_valid & ~stall_s;
  end

  // Next counter value per register: net of one possible issue and up to
  // two retires (wb + kill), saturating at zero with an underflow flag.
  always_comb begin
    busy_nxt_s = 16'h0000;
    under_s    = 16'h0000;
    for (int r = 0; r < 16; r++) begin
      sum_s[r] = {1'b0, cnt_r[r]}
               + (CNT_W+1)'(fire_s & issue_wb_en & (issue_dest == 4'(r)));
      dec_s[r] = (CNT_W+1)'(wb_valid & (wb_dest == 4'(r)))
               + (CNT_W+1)'(kill_valid & (kill_dest == 4'(r)));
      if (dec_s[r] > sum_s[r]) begin
        under_s[r]   = 1'b1;
        cnt_nxt_s[r] = CNT_ZERO;
      end else begin
        under_s[r]   = 1'b0;
        cnt_nxt_s[r] = CNT_W'(sum_s[r] - dec_s[r]);
      end
      busy_nxt_s[r] = (cnt_nxt_s[r] != CNT_ZERO);
    end
  end

  // Counter, busy and sticky error state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < 16; r++) begin
        cnt_r[r] <= CNT_ZERO;
      end
      busy_r <= 16'h0000;
      err_r  <= 1'b0;
    end else begin
      for (int r = 0; r < 16; r++) begin
        cnt_r[r] <= cnt_nxt_s[r];
      end
      busy_r <= busy_nxt_s;
      err_r  <= err_r | (|under_s);
    end
  end

  assign stall      = stall_s;
  assign issue_fire = fire_s;
  assign busy       = busy_r;
  assign err        = err_r;

endmodule
